// File: rtl/mandel_coord_gen_if.sv
// rtl/mandel_coord_gen_if.sv - coordinate stream from generator to Mandelbrot iterator
interface mandel_coord_gen_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic [26:0]   out_c_r;
    logic [26:0]   out_c_i;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          out_val;
    logic          out_rdy;

    modport master (
        output out_c_r, out_c_i, pix_x, pix_y, out_val,
        input  out_rdy
    );

    modport slave (
        input  out_c_r, out_c_i, pix_x, pix_y, out_val,
        output out_rdy
    );
endinterface

// File: rtl/mandel_coord_gen.sv
// rtl/mandel_coord_gen.sv - raster-order Q4.23 coordinate generator; MANDEL_COORD_CONT_FRAME_EN enables continuous frames
module mandel_coord_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = $clog2(H_RES),
    parameter int YW    = $clog2(V_RES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [26:0]               x_min,
    input  logic [26:0]               y_max,
    input  logic [26:0]               step,
    mandel_coord_gen_if.master        out_if,
    output logic                      busy,
    output logic                      frame_done
);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [26:0]   xmin_q, xmin_d;
    logic [26:0]   step_q, step_d;
    logic [26:0]   cr_q, cr_d;
    logic [26:0]   ci_q, ci_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;

    logic xfer;
    logic last_pix;
    logic load;

    assign xfer     = (state_q == S_RUN) && out_if.out_rdy;
    assign last_pix = (px_q == X_LAST) && (py_q == Y_LAST);

`ifdef MANDEL_COORD_CONT_FRAME_EN
    // The DONE cycle doubles as the load cycle of the next frame.
    assign load = ((state_q == S_IDLE) && start) || (state_q == S_DONE);
`else
    assign load = (state_q == S_IDLE) && start;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (xfer && last_pix) state_d = S_DONE;
`ifdef MANDEL_COORD_CONT_FRAME_EN
            S_DONE: state_d = S_RUN;
`else
            S_DONE: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_if.out_val = (state_q == S_RUN);
        frame_done     = (state_q == S_DONE);
`ifdef MANDEL_COORD_CONT_FRAME_EN
        busy           = (state_q == S_RUN) || (state_q == S_DONE);
`else
        busy           = (state_q == S_RUN);
`endif
    end

    // Row restart reloads the latched x_min so c_r never accumulates across rows.
    always_comb begin
        xmin_d = xmin_q;
        step_d = step_q;
        cr_d   = cr_q;
        ci_d   = ci_q;
        px_d   = px_q;
        py_d   = py_q;
        if (load) begin
            xmin_d = x_min;
            step_d = step;
            cr_d   = x_min;
            ci_d   = y_max;
            px_d   = '0;
            py_d   = '0;
        end else if (xfer && !last_pix) begin
            if (px_q == X_LAST) begin
                px_d = '0;
                py_d = py_q + 1'b1;
                cr_d = xmin_q;
                ci_d = ci_q - step_q;
            end else begin
                px_d = px_q + 1'b1;
                cr_d = cr_q + step_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xmin_q <= '0;
            step_q <= '0;
            cr_q   <= '0;
            ci_q   <= '0;
            px_q   <= '0;
            py_q   <= '0;
        end else begin
            xmin_q <= xmin_d;
            step_q <= step_d;
            cr_q   <= cr_d;
            ci_q   <= ci_d;
            px_q   <= px_d;
            py_q   <= py_d;
        end
    end

    assign out_if.out_c_r = cr_q;
    assign out_if.out_c_i = ci_q;
    assign out_if.pix_x   = px_q;
    assign out_if.pix_y   = py_q;
endmodule

// File: doc/mandel_coord_gen.md
Name: mandel_coord_gen

Overview:
- Upstream stage of the Mandelbrot iterator.
- Scans a rectangular pixel grid in raster order and emits one complex coordinate (c_r, c_i) per pixel in Q4.23, plus the pixel's (x, y) tag.
- Output uses a valid/ready handshake that connects directly to the iterator's in_val/in_rdy.
- Coordinates are computed incrementally by stepping. There are no multipliers.

Parameters:
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- XW, $clog2(H_RES), width of pix_x.
- YW, $clog2(V_RES), width of pix_y.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- start  input  1  single-cycle pulse; begins a frame when in IDLE.
- x_min  input  27  signed Q4.23 real coordinate of column 0.
- y_max  input  27  signed Q4.23 imaginary coordinate of row 0.
- step  input  27  signed Q4.23 per-pixel increment, used for both axes.
- out_c_r  output  27  signed Q4.23 real coordinate.
- out_c_i  output  27  signed Q4.23 imaginary coordinate.
- pix_x  output  XW  column of the current coordinate.
- pix_y  output  YW  row of the current coordinate.
- out_val  output  1  coordinate valid.
- out_rdy  input  1  downstream accepts.
- busy  output  1  high from start acceptance until frame end.
- frame_done  output  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high.
- Reset values: state=IDLE; out_val=0, busy=0, frame_done=0; pix_x=0, pix_y=0; out_c_r=0, out_c_i=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - When start=1, latch x_min, y_max and step into internal registers.
  - Set out_c_r=x_min, out_c_i=y_max, pix_x=0, pix_y=0.
  - Go to RUN next cycle. First out_val is the cycle after start (latency 1).
- RUN:
  - out_val=1 and busy=1.
  - While out_rdy=0, outputs hold stable.
  - A transfer occurs when out_val && out_rdy. At most one pixel per cycle, so back-to-back transfers are allowed.
- On a transfer with pix_x < H_RES-1:
  - pix_x+=1.
  - out_c_r += step.
- On a transfer with pix_x == H_RES-1 and pix_y < V_RES-1:
  - pix_x=0, pix_y+=1.
  - out_c_r=latched x_min.
  - out_c_i -= step.
- On a transfer at the last pixel (H_RES-1, V_RES-1):
  - out_val drops next cycle.
  - Go to DONE.
- DONE:
  - frame_done=1 for exactly one cycle, busy=0.
  - Then IDLE.
- Arithmetic: 27-bit two's-complement add/subtract with wrap-around; no saturation. The iterator's escape test handles out-of-range values.
- Input changes: start while busy is ignored. x_min, y_max and step changes after start do not affect the current frame.
- Reset mid-frame: returns to IDLE next edge with out_val=0. No frame_done pulse. The downstream side discards any partial frame.
- start and reset asserted together: reset wins.
- Drift: total step accumulation error is zero because additions are exact in Q4.23. Row restart reloads x_min to prevent drift on c_r.

Optional Feature:
- Macro: MANDEL_COORD_CONT_FRAME_EN.
- Defined:
  - DONE goes straight to RUN instead of IDLE.
  - x_min, y_max and step are re-sampled from the ports in that DONE cycle.
  - frame_done still pulses, and busy stays high.
  - The next frame's first out_val appears the cycle after DONE.
  - start is ignored except from IDLE after reset.
- Undefined: one frame per start pulse, as above.

Test Plan:
- H_RES=4, V_RES=3, x_min=27'h7000000 (-2.0), y_max=27'h0800000 (1.0), step=27'h0400000 (0.5), out_rdy=1, start pulse:
  - 12 transfers on consecutive cycles.
  - Row 0 c_r = -2.0, -1.5, -1.0, -0.5, with c_i=1.0.
  - Row 2 c_i=0.0.
  - frame_done pulses once, one cycle after the 12th transfer.
- Same config with out_rdy toggled 1,0,0,1 repeating:
  - Outputs stable while out_rdy=0.
  - Still exactly 12 unique (pix_x, pix_y) pairs in raster order.
- Pulse start again during RUN with different x_min: no effect on the sequence; c_r of pixel (0,1) equals -2.0.
- Assert reset at pixel (2,1):
  - Next cycle out_val=0, busy=0, pix_x=0, pix_y=0, no frame_done.
  - A new start then restarts from (0,0).
- x_min=27'h3FFFFFF (max positive), step=1, H_RES=4: c_r wraps to 27'h4000000 on the second pixel (two's-complement wrap confirmed).
- With MANDEL_COORD_CONT_FRAME_EN defined: two frames run back-to-back, each with a frame_done pulse, and the second frame uses port values sampled in the DONE cycle.
